// File: rtl/ofmap_stream_unchainer.sv
// Drains one accumulation-buffer bank per bank_rdy handshake, splitting each OC0-wide
// chained word into OUT_LANES-wide beats on a valid/ready stream with optional ReLU.
module ofmap_stream_unchainer #(
    parameter int DATA_WIDTH      = 32,
    parameter int OC0             = 4,
    parameter int OUT_LANES       = 1,
    parameter int BANK_ADDR_WIDTH = 16,
    parameter int COUNTER_WID     = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            config_en,
    input  logic [BANK_ADDR_WIDTH-1:0]      config_words,
    input  logic [COUNTER_WID-1:0]          config_banks,
    input  logic                            config_relu,
    input  logic                            bank_rdy,
    output logic                            bank_done,
    output logic                            ren,
    output logic [BANK_ADDR_WIDTH-1:0]      raddr,
    input  logic [DATA_WIDTH*OC0-1:0]       rdata,
    output logic [DATA_WIDTH*OUT_LANES-1:0] ofmap_dat,
    output logic                            ofmap_vld,
    input  logic                            ofmap_rdy,
    output logic [COUNTER_WID-1:0]          bank_count,
    output logic                            all_done
);

    localparam int BEATS   = OC0 / OUT_LANES;
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WORD_W  = DATA_WIDTH * OC0;
    localparam int BEAT_DW = DATA_WIDTH * OUT_LANES;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BANK,
        READ,
        LOAD,
        SHIFT,
        DONE_BANK,
        FINISHED
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic [BANK_ADDR_WIDTH-1:0] words_q;
    logic [BANK_ADDR_WIDTH-1:0] addr;
    logic [COUNTER_WID-1:0]     banks_q;
    logic [COUNTER_WID-1:0]     count_q;
    logic [COUNTER_WID-1:0]     count_inc;
    logic                       relu_q;
    logic [BEAT_W-1:0]          beat;
    logic [WORD_W-1:0]          shreg;
    logic [WORD_W-1:0]          load_word;
    logic                       cfg_ok;
    logic                       xfer;
    logic                       last_beat;
    logic                       last_word;

    assign cfg_ok    = config_en && ((state == IDLE) || (state == FINISHED));
    assign xfer      = (state == SHIFT) && ofmap_rdy;
    assign last_beat = (beat == LAST_BEAT);
    assign last_word = (addr == (words_q - BANK_ADDR_WIDTH'(1)));
    assign count_inc = count_q + COUNTER_WID'(1);

    // addr only moves on the cycle that enters READ, so it doubles as a held raddr.
    assign ren        = (state == READ);
    assign raddr      = addr;
    assign ofmap_vld  = (state == SHIFT);
    assign ofmap_dat  = shreg[BEAT_DW-1:0];
    assign bank_done  = (state == DONE_BANK);
    assign all_done   = (state == FINISHED);
    assign bank_count = count_q;

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        load_word = rdata;
        for (int i = 0; i < OC0; i++) begin
            if (relu_q && rdata[DATA_WIDTH*(i+1)-1]) begin
                load_word[DATA_WIDTH*i +: DATA_WIDTH] = '0;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (config_en) state_next = WAIT_BANK;
            WAIT_BANK: if (bank_rdy) state_next = READ;
            READ:      state_next = LOAD;
            LOAD:      state_next = SHIFT;
            SHIFT:     if (xfer && last_beat) state_next = last_word ? DONE_BANK : READ;
            DONE_BANK: state_next = (count_inc == banks_q) ? FINISHED : WAIT_BANK;
            FINISHED:  if (config_en) state_next = WAIT_BANK;
            default:   state_next = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignment so each reads pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            words_q <= '0;
            banks_q <= '0;
            relu_q  <= 1'b0;
            count_q <= '0;
            addr    <= '0;
            beat    <= '0;
            shreg   <= '0;
        end else begin
            state <= state_next;
            if (cfg_ok) begin
                words_q <= (config_words == '0) ? BANK_ADDR_WIDTH'(1) : config_words;
                banks_q <= (config_banks == '0) ? COUNTER_WID'(1) : config_banks;
                relu_q  <= config_relu;
                count_q <= '0;
            end
            if ((state == WAIT_BANK) && bank_rdy) begin
                addr <= '0;
            end
            if (state == LOAD) begin
                shreg <= load_word;
                beat  <= '0;
            end
            if (xfer) begin
                shreg <= shreg >> BEAT_DW;
                if (!last_beat) begin
                    beat <= beat + BEAT_W'(1);
                end else if (!last_word) begin
                    addr <= addr + BANK_ADDR_WIDTH'(1);
                end
            end
            if (state == DONE_BANK) begin
                count_q <= count_inc;
            end
        end
    end

endmodule

// File: tb/tb_ofmap_stream_unchainer.sv
// Bench for ofmap_stream_unchainer: one instance with 1 output lane, one with 2 lanes,
// each fed by its own read-port memory model and checked against a stream model.
module tb_ofmap_stream_unchainer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        config_en;
    logic [15:0] config_words;
    logic [15:0] config_banks;
    logic        config_relu;
    logic        bank_rdy;
    logic        ofmap_rdy;

    logic        ren_o       [2];
    logic [15:0] raddr_o     [2];
    logic [127:0] rdata_i    [2];
    logic        vld_o       [2];
    logic        bank_done_o [2];
    logic        all_done_o  [2];
    logic [15:0] count_o     [2];
    logic [31:0] dat1;
    logic [63:0] dat2;

    logic [127:0] mem [4][8];
    logic [63:0]  exp_q [$];
    logic [63:0]  obs_q [2][$];
    logic [15:0]  raddr_q [2][$];
    logic [1:0]   cur_bank [2];
    int           done_cnt [2];
    int           hold_viol [2];
    int           stall_cnt [2];
    logic         prev_stall [2];
    logic [63:0]  prev_dat [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ofmap_stream_unchainer #(.OUT_LANES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .config_en(config_en), .config_words(config_words),
        .config_banks(config_banks), .config_relu(config_relu), .bank_rdy(bank_rdy),
        .bank_done(bank_done_o[0]), .ren(ren_o[0]), .raddr(raddr_o[0]), .rdata(rdata_i[0]),
        .ofmap_dat(dat1), .ofmap_vld(vld_o[0]), .ofmap_rdy(ofmap_rdy),
        .bank_count(count_o[0]), .all_done(all_done_o[0])
    );

    ofmap_stream_unchainer #(.OUT_LANES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .config_en(config_en), .config_words(config_words),
        .config_banks(config_banks), .config_relu(config_relu), .bank_rdy(bank_rdy),
        .bank_done(bank_done_o[1]), .ren(ren_o[1]), .raddr(raddr_o[1]), .rdata(rdata_i[1]),
        .ofmap_dat(dat2), .ofmap_vld(vld_o[1]), .ofmap_rdy(ofmap_rdy),
        .bank_count(count_o[1]), .all_done(all_done_o[1])
    );

    function automatic logic [63:0] mon_dat(input int i);
        return (i == 0) ? {32'd0, dat1} : dat2;
    endfunction

    // Synchronous read port: data appears the cycle after ren.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ren_o[i]) rdata_i[i] <= mem[cur_bank[i]][raddr_o[i][2:0]];
        end
    end

    // Transfers, reads and bank pulses are recorded away from the clock edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                obs_q[i].delete();
                raddr_q[i].delete();
                done_cnt[i]   <= 0;
                hold_viol[i]  <= 0;
                stall_cnt[i]  <= 0;
                cur_bank[i]   <= 2'd0;
                prev_stall[i] <= 1'b0;
                prev_dat[i]   <= '0;
            end else begin
                if (vld_o[i] && ofmap_rdy) obs_q[i].push_back(mon_dat(i));
                if (ren_o[i]) raddr_q[i].push_back(raddr_o[i]);
                if (bank_done_o[i]) begin
                    done_cnt[i] <= done_cnt[i] + 1;
                    cur_bank[i] <= cur_bank[i] + 2'd1;
                end
                if (prev_stall[i] && (!vld_o[i] || (mon_dat(i) !== prev_dat[i])))
                    hold_viol[i] <= hold_viol[i] + 1;
                if (vld_o[i] && !ofmap_rdy) stall_cnt[i] <= stall_cnt[i] + 1;
                prev_stall[i] <= vld_o[i] && !ofmap_rdy;
                prev_dat[i]   <= mon_dat(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; config_en = 1'b0; bank_rdy = 1'b0; ofmap_rdy = 1'b0;
        config_words = '0; config_banks = '0; config_relu = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic configure(input int n, input int b, input bit relu);
        config_words = 16'(n); config_banks = 16'(b); config_relu = relu;
        config_en = 1'b1;
        tick();
        config_en = 1'b0;
    endtask

    task automatic set_word(input int bank, input int w, input int e3, input int e2,
                            input int e1, input int e0);
        logic [31:0] a, b, c, d;
        a = e3; b = e2; c = e1; d = e0;
        mem[bank][w] = {a, b, c, d};
    endtask

    // Expected stream: every element of every word of every bank in order, ReLU applied,
    // packed lane0-first into beats of `lanes` elements.
    task automatic model_stream(input int lanes, input int n, input int b, input bit relu);
        int nn, bb, v;
        int elems[$];
        logic [63:0] beat;
        logic [31:0] u;
        nn = (n == 0) ? 1 : n;
        bb = (b == 0) ? 1 : b;
        exp_q.delete();
        for (int bank = 0; bank < bb; bank++)
            for (int w = 0; w < nn; w++)
                for (int e = 0; e < 4; e++) begin
                    v = int'(signed'(mem[bank][w][32*e +: 32]));
                    if (relu && v < 0) v = 0;
                    elems.push_back(v);
                end
        for (int k = 0; k < elems.size(); k += lanes) begin
            beat = '0;
            for (int j = 0; j < lanes; j++) begin
                u = elems[k+j];
                beat = beat | ({32'd0, u} << (32*j));
            end
            exp_q.push_back(beat);
        end
    endtask

    task automatic basic_mem();
        for (int b = 0; b < 4; b++) begin
            set_word(b, 0, 4, 3, 2, 1);
            set_word(b, 1, 8, 7, 6, 5);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; config_en = 1'b0; bank_rdy = 1'b0; ofmap_rdy = 1'b1;
        config_words = 16'd2; config_banks = 16'd1; config_relu = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b1;
        bank_rdy = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        total++; if (vld_o[0] !== 1'b0) begin bad++; $display("FAIL reset_vld got=%0b want=0", vld_o[0]); end
        total++; if (ren_o[0] !== 1'b0) begin bad++; $display("FAIL reset_ren got=%0b want=0", ren_o[0]); end
        total++; if (bank_done_o[0] !== 1'b0) begin bad++; $display("FAIL reset_bank_done got=%0b want=0", bank_done_o[0]); end
        total++; if (all_done_o[0] !== 1'b0) begin bad++; $display("FAIL reset_all_done got=%0b want=0", all_done_o[0]); end
        total++; if (count_o[0] !== 16'd0) begin bad++; $display("FAIL reset_bank_count got=%0d want=0", count_o[0]); end
        total++; if (dat1 !== 32'd0) begin bad++; $display("FAIL reset_dat got=%0h want=0", dat1); end
        total++; if (raddr_q[0].size() != 0) begin bad++; $display("FAIL reset_ren_seen got=%0d want=0", raddr_q[0].size()); end
        bank_rdy = 1'b0;
    endtask

    task automatic test_basic_drain();
        int cyc;
        do_reset();
        basic_mem();
        configure(2, 1, 0);
        bank_rdy = 1'b1; ofmap_rdy = 1'b1;
        tick(); tick();
        total++; if (vld_o[0] !== 1'b0) begin bad++; $display("FAIL basic_early_vld got=%0b want=0", vld_o[0]); end
        tick();
        total++; if (vld_o[0] !== 1'b1) begin bad++; $display("FAIL basic_first_vld got=%0b want=1", vld_o[0]); end
        total++; if (dat1 !== 32'd1) begin bad++; $display("FAIL basic_first_dat got=%0d want=1", dat1); end
        cyc = 3;
        while (!bank_done_o[0] && cyc < 100) begin tick(); cyc++; end
        total++; if (cyc != 13) begin bad++; $display("FAIL basic_bank_cycles got=%0d want=13", cyc); end
        bank_rdy = 1'b0;
        tick();
        total++; if (all_done_o[0] !== 1'b1) begin bad++; $display("FAIL basic_all_done got=%0b want=1", all_done_o[0]); end
        total++; if (count_o[0] !== 16'd1) begin bad++; $display("FAIL basic_bank_count got=%0d want=1", count_o[0]); end
        total++; if (done_cnt[0] != 1) begin bad++; $display("FAIL basic_done_pulses got=%0d want=1", done_cnt[0]); end
        total++;
        if (raddr_q[0].size() != 2 || raddr_q[0][0] !== 16'd0 || raddr_q[0][1] !== 16'd1) begin
            bad++; $display("FAIL basic_raddr got_reads=%0d want=2 (addr 0 then 1)", raddr_q[0].size());
        end
        model_stream(1, 2, 1, 0);
        total++; if (obs_q[0].size() != exp_q.size()) begin bad++; $display("FAIL basic_len got=%0d want=%0d", obs_q[0].size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < obs_q[0].size(); k++) begin
            total++; if (obs_q[0][k] !== exp_q[k]) begin bad++; $display("FAIL basic_beat%0d got=%0h want=%0h", k, obs_q[0][k], exp_q[k]); end
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        do_reset();
        basic_mem();
        configure(2, 1, 0);
        bank_rdy = 1'b1;
        cyc = 0;
        while (!all_done_o[0] && cyc < 200) begin
            ofmap_rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            tick(); cyc++;
        end
        total++; if (all_done_o[0] !== 1'b1) begin bad++; $display("FAIL bp_timeout got=%0b want=1", all_done_o[0]); end
        total++; if (stall_cnt[0] == 0) begin bad++; $display("FAIL bp_stalls got=%0d want>0", stall_cnt[0]); end
        total++; if (hold_viol[0] != 0) begin bad++; $display("FAIL bp_hold got=%0d want=0", hold_viol[0]); end
        model_stream(1, 2, 1, 0);
        total++; if (obs_q[0].size() != exp_q.size()) begin bad++; $display("FAIL bp_len got=%0d want=%0d", obs_q[0].size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < obs_q[0].size(); k++) begin
            total++; if (obs_q[0][k] !== exp_q[k]) begin bad++; $display("FAIL bp_beat%0d got=%0h want=%0h", k, obs_q[0][k], exp_q[k]); end
        end
        bank_rdy = 1'b0;
    endtask

    task automatic test_relu_lanes();
        logic [63:0] want [2][2];
        int cyc;
        want[1][0] = 64'h0;                    want[1][1] = {32'd0, 32'd7};
        want[0][0] = {32'hFFFFFFFF, 32'd0};    want[0][1] = {32'hFFFFFFFB, 32'd7};
        for (int r = 1; r >= 0; r--) begin
            do_reset();
            set_word(0, 0, -5, 7, -1, 0);
            configure(1, 1, r[0]);
            bank_rdy = 1'b1; ofmap_rdy = 1'b1;
            cyc = 0;
            while (!all_done_o[1] && cyc < 50) begin tick(); cyc++; end
            total++; if (obs_q[1].size() != 2) begin bad++; $display("FAIL relu%0d_len got=%0d want=2", r, obs_q[1].size()); end
            for (int k = 0; k < 2 && k < obs_q[1].size(); k++) begin
                total++;
                if (obs_q[1][k] !== want[r][k]) begin
                    bad++; $display("FAIL relu%0d_beat%0d got=%0h want=%0h", r, k, obs_q[1][k], want[r][k]);
                end
            end
            bank_rdy = 1'b0;
        end
    endtask

    task automatic test_multi_bank();
        int cyc;
        do_reset();
        for (int b = 0; b < 3; b++) set_word(b, 0, 10*b+4, 10*b+3, -(10*b+2), 10*b+1);
        configure(1, 3, 0);
        ofmap_rdy = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            bank_rdy = 1'b1;
            tick();
            bank_rdy = 1'b0;
            if (k == 1) begin
                tick(); tick();
                config_words = 16'd5; config_banks = 16'd1; config_relu = 1'b1; config_en = 1'b1;
                tick();
                config_en = 1'b0; config_words = 16'd1; config_banks = 16'd3; config_relu = 1'b0;
            end
            cyc = 0;
            while (!bank_done_o[0] && cyc < 30) begin tick(); cyc++; end
            total++; if (bank_done_o[0] !== 1'b1) begin bad++; $display("FAIL multi_done%0d_timeout got=0 want=1", k); end
            tick();
            total++; if (count_o[0] !== 16'(k)) begin bad++; $display("FAIL multi_count%0d got=%0d want=%0d", k, count_o[0], k); end
            total++; if (all_done_o[0] !== (k == 3)) begin bad++; $display("FAIL multi_all_done%0d got=%0b want=%0b", k, all_done_o[0], k == 3); end
        end
        total++; if (done_cnt[0] != 3) begin bad++; $display("FAIL multi_pulses got=%0d want=3", done_cnt[0]); end
        model_stream(1, 1, 3, 0);
        total++; if (obs_q[0].size() != exp_q.size()) begin bad++; $display("FAIL multi_len got=%0d want=%0d", obs_q[0].size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < obs_q[0].size(); k++) begin
            total++; if (obs_q[0][k] !== exp_q[k]) begin bad++; $display("FAIL multi_beat%0d got=%0h want=%0h", k, obs_q[0][k], exp_q[k]); end
        end
        configure(1, 3, 0);
        total++; if (count_o[0] !== 16'd0) begin bad++; $display("FAIL multi_reconfig_count got=%0d want=0", count_o[0]); end
        total++; if (all_done_o[0] !== 1'b0) begin bad++; $display("FAIL multi_reconfig_all_done got=%0b want=0", all_done_o[0]); end
    endtask

    task automatic test_reset_mid_bank();
        int cyc;
        do_reset();
        basic_mem();
        configure(2, 1, 0);
        bank_rdy = 1'b1; ofmap_rdy = 1'b1;
        cyc = 0;
        while (!(vld_o[0] && raddr_o[0] == 16'd1) && cyc < 50) begin tick(); cyc++; end
        total++; if (vld_o[0] !== 1'b1) begin bad++; $display("FAIL midrst_reach_word1 got=%0b want=1", vld_o[0]); end
        rst_n = 1'b0;
        tick();
        total++; if (vld_o[0] !== 1'b0) begin bad++; $display("FAIL midrst_vld got=%0b want=0", vld_o[0]); end
        total++; if (count_o[0] !== 16'd0) begin bad++; $display("FAIL midrst_count got=%0d want=0", count_o[0]); end
        total++; if (bank_done_o[0] !== 1'b0) begin bad++; $display("FAIL midrst_bank_done got=%0b want=0", bank_done_o[0]); end
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        total++; if (done_cnt[0] != 0) begin bad++; $display("FAIL midrst_pulses got=%0d want=0", done_cnt[0]); end
        total++; if (raddr_q[0].size() != 0) begin bad++; $display("FAIL midrst_reads got=%0d want=0", raddr_q[0].size()); end
        bank_rdy = 1'b0;
    endtask

    task automatic test_random();
        int n, b, sel, cyc, bb;
        bit relu;
        for (int it = 0; it < 8; it++) begin
            sel = it % 2;
            do_reset();
            for (int bk = 0; bk < 4; bk++)
                for (int w = 0; w < 8; w++)
                    mem[bk][w] = {$urandom(), $urandom(), $urandom(), $urandom()};
            n = $urandom_range(0, 5); b = $urandom_range(0, 3); relu = 1'($urandom_range(0, 1));
            bb = (b == 0) ? 1 : b;
            configure(n, b, relu);
            cyc = 0;
            while (!all_done_o[sel] && cyc < 3000) begin
                bank_rdy  = ($urandom_range(0, 3) != 0);
                ofmap_rdy = ($urandom_range(0, 3) != 0);
                tick(); cyc++;
            end
            bank_rdy = 1'b0;
            total++; if (all_done_o[sel] !== 1'b1) begin bad++; $display("FAIL rnd%0d_timeout got=%0b want=1", it, all_done_o[sel]); end
            total++; if (count_o[sel] !== 16'(bb)) begin bad++; $display("FAIL rnd%0d_count got=%0d want=%0d", it, count_o[sel], bb); end
            total++; if (done_cnt[sel] != bb) begin bad++; $display("FAIL rnd%0d_pulses got=%0d want=%0d", it, done_cnt[sel], bb); end
            total++; if (hold_viol[sel] != 0) begin bad++; $display("FAIL rnd%0d_hold got=%0d want=0", it, hold_viol[sel]); end
            model_stream(sel + 1, n, b, relu);
            total++; if (obs_q[sel].size() != exp_q.size()) begin bad++; $display("FAIL rnd%0d_len got=%0d want=%0d", it, obs_q[sel].size(), exp_q.size()); end
            for (int k = 0; k < exp_q.size() && k < obs_q[sel].size(); k++) begin
                total++;
                if (obs_q[sel][k] !== exp_q[k]) begin
                    bad++; $display("FAIL rnd%0d_beat%0d got=%0h want=%0h", it, k, obs_q[sel][k], exp_q[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_drain();
        test_backpressure();
        test_relu_lanes();
        test_multi_bank();
        test_reset_mid_bank();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ofmap_stream_unchainer.md
Name: ofmap_stream_unchainer

Overview:
Drains one filled bank of the accumulation double buffer per handshake. It reads OC0-wide chained words through a synchronous read port and unchains each word into OUT_LANES-wide beats on a valid/ready ofmap stream. It applies optional ReLU, counts completed banks and flags completion of the whole layer. It sits between the accum double buffer read port and the testbench/ofmap stream, alongside the main FSM that owns bank switching.

Parameters:
DATA_WIDTH, 32, width of one output element (signed two's complement)
OC0, 4, elements per chained buffer word
OUT_LANES, 1, elements per output beat; must divide OC0; BEATS = OC0/OUT_LANES
BANK_ADDR_WIDTH, 16, width of the read address and of the word count
COUNTER_WID, 16, width of the bank counter and bank total

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
config_en  in  1  load configuration (accepted only in IDLE or FINISHED)
config_words  in  BANK_ADDR_WIDTH  chained words per bank (N)
config_banks  in  COUNTER_WID  banks per layer (B)
config_relu  in  1  1 = clamp negative elements to 0
bank_rdy  in  1  read bank holds valid data; level, sampled in WAIT_BANK
bank_done  out  1  one-cycle pulse: current bank fully drained, bank may switch
ren  out  1  buffer read enable
raddr  out  BANK_ADDR_WIDTH  buffer read address
rdata  in  DATA_WIDTH*OC0  read data, valid exactly 1 cycle after ren
ofmap_dat  out  DATA_WIDTH*OUT_LANES  output beat
ofmap_vld  out  1  beat valid
ofmap_rdy  in  1  consumer ready
bank_count  out  COUNTER_WID  banks completed since last config_en
all_done  out  1  level, high in FINISHED

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; all outputs 0; shift register, word address, beat index and config registers cleared. Reset mid-transfer aborts immediately with no bank_done.
- Config: config_en in IDLE/FINISHED latches words/banks/relu, clears bank_count, and moves to WAIT_BANK next cycle. config_en in any other state is ignored. A value of 0 for config_words or config_banks is treated as 1.
- States:
  - IDLE: waits for config_en.
  - WAIT_BANK: when bank_rdy=1, word address := 0, next state READ.
  - READ: ren=1 and raddr=word address for exactly one cycle, next state LOAD. raddr holds its last value while ren=0.
  - LOAD: captures rdata into the shift register, beat := 0, next state SHIFT. If relu=1, each element with its MSB set is stored as 0.
  - SHIFT: ofmap_vld=1. Lane j of ofmap_dat = element beat*OUT_LANES+j. Element i occupies rdata[DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
    - On vld&&rdy with beat<BEATS-1: beat++.
    - On vld&&rdy with beat=BEATS-1 and addr<N-1: addr++, next state READ.
    - On vld&&rdy with beat=BEATS-1 and addr=N-1: next state DONE_BANK.
  - DONE_BANK: bank_done=1 for this cycle; bank_count++. If the new count = B, next state FINISHED, otherwise WAIT_BANK.
  - FINISHED: all_done=1; bank_count holds B; config_en restarts.
- Handshake: while vld=1 and rdy=0, ofmap_dat and vld hold stable. vld never drops without a transfer. rdy is ignored when vld=0.
- Latency: bank_rdy high to first vld = 3 cycles (WAIT_BANK→READ→LOAD→SHIFT). Each word costs 2 overhead cycles plus BEATS transfer cycles. A bank with full rdy takes N*(BEATS+2)+1 cycles after WAIT_BANK exit.
- bank_rdy is not re-sampled until the next WAIT_BANK. Holding it high across DONE_BANK starts the next bank immediately.
- Counters never wrap: addr ≤ N-1, bank_count ≤ B.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release with no config → vld, ren, bank_done, all_done, bank_count all 0 and ren never asserted.
- Basic drain (OC0=4, OUT_LANES=1, N=2, B=1, relu=0): rdata word0 = {4,3,2,1}, word1 = {8,7,6,5}, rdy=1 → ofmap_dat sequence 1..8. ren occurs at raddr 0 then 1. First vld appears 3 cycles after bank_rdy. bank_done pulses once, followed by all_done=1 and bank_count=1.
- Backpressure: same stimulus with rdy toggling 1,0,0,1,… → no element is dropped or duplicated, dat is stable during every rdy=0 cycle, and the output order is still 1..8.
- ReLU and lanes (OUT_LANES=2): word {-5,7,-1,0}, relu=1 → two beats {lane0=0,lane1=0} then {lane0=7,lane1=0}. With relu=0, the same word gives {0,-1} then {7,-5} (lane0 first in each pair).
- Multi-bank (N=1, B=3): pulse bank_rdy three times → three bank_done pulses, bank_count goes 1, 2, 3, and all_done is set only after the third pulse. A config_en asserted mid-bank is ignored. A config_en asserted in FINISHED clears bank_count to 0.
- Reset mid-bank: assert rst_n=0 during SHIFT of word1 → the next cycle returns to IDLE with vld=0 and bank_count=0, and no bank_done pulse occurs.
